// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory with byte, halfword and word accesses,
// selectable lane order, optional wait states and request rejection.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous active-high reset
//   inputAddress byte address, only [ADDR_WIDTH-1:0] used
//   inputData    write data, right-justified for sub-word sizes
//   MemRead      read request
//   MemWrite     write request
//   accessSize   00 byte, 01 halfword, 10 word, 11 illegal
//   signExtend   1 sign-extends sub-word reads, 0 zero-extends
//   outputData   registered read data
//   readValid    one-cycle pulse when outputData was updated
//   busy         access in progress, new requests ignored
//   accessErr    one-cycle pulse when a request was rejected
module data_memory_bytelane #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inputAddress,
    input  logic [31:0] inputData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  accessSize,
    input  logic        signExtend,
    output logic [31:0] outputData,
    output logic        readValid,
    output logic        busy,
    output logic        accessErr
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic                  rd_q, rd_d;
    logic [31:0]           out_q, out_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic [7:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]       acc_addr;
    logic [31:0]                 acc_data;
    logic [1:0]                  acc_size;
    logic                        acc_sext;
    logic                        acc_rd;
    logic [3:0][ADDR_WIDTH-1:0]  lane_addr;
    logic [3:0][7:0]             rb;
    logic [3:0][7:0]             wb;
    logic [3:0]                  be;
    logic [15:0]                 hw;
    logic [31:0]                 rdata;
    logic                        req;
    logic                        bad;
    logic                        fire;
    logic                        mem_we;

    // Upper address bits wrap away; kept only to show they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^inputAddress[31:ADDR_WIDTH];

    // Without wait states the access happens on the accepting edge,
    // so it works straight from the inputs; otherwise from the capture.
    always_comb begin
        if (WS == 4'd0) begin
            acc_addr = inputAddress[ADDR_WIDTH-1:0];
            acc_data = inputData;
            acc_size = accessSize;
            acc_sext = signExtend;
            acc_rd   = MemRead;
        end else begin
            acc_addr = addr_q;
            acc_data = data_q;
            acc_size = size_q;
            acc_sext = sext_q;
            acc_rd   = rd_q;
        end
    end

    // Lane k is the byte at base+k; aligned accesses never wrap mid-access.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = acc_addr + ADDR_WIDTH'(k);
            rb[k]        = mem_q[lane_addr[k]];
        end
        hw    = BIG_ENDIAN ? {rb[0], rb[1]} : {rb[1], rb[0]};
        rdata = '0;
        unique case (acc_size)
            SZ_B:    rdata = {{24{acc_sext & rb[0][7]}}, rb[0]};
            SZ_H:    rdata = {{16{acc_sext & hw[15]}}, hw};
            SZ_W:    rdata = BIG_ENDIAN ? {rb[0], rb[1], rb[2], rb[3]}
                                        : {rb[3], rb[2], rb[1], rb[0]};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        be = '0;
        wb = '0;
        unique case (acc_size)
            SZ_B: begin
                be    = 4'b0001;
                wb[0] = acc_data[7:0];
            end
            SZ_H: begin
                be    = 4'b0011;
                wb[0] = BIG_ENDIAN ? acc_data[15:8] : acc_data[7:0];
                wb[1] = BIG_ENDIAN ? acc_data[7:0] : acc_data[15:8];
            end
            SZ_W: begin
                be = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    wb[k] = BIG_ENDIAN ? acc_data[31-8*k -: 8]
                                       : acc_data[8*k +: 8];
                end
            end
            default: be = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        sext_d   = sext_q;
        rd_d     = rd_q;
        out_d    = out_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        fire     = 1'b0;
        req      = MemRead | MemWrite;
        bad      = (MemRead & MemWrite)
                 | (accessSize == 2'b11)
                 | ((accessSize == SZ_H) & inputAddress[0])
                 | ((accessSize == SZ_W) & (inputAddress[1:0] != 2'b00));
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else if (WS == 4'd0) begin
                        fire = 1'b1;
                    end else begin
                        addr_d  = inputAddress[ADDR_WIDTH-1:0];
                        data_d  = inputData;
                        size_d  = accessSize;
                        sext_d  = signExtend;
                        rd_d    = MemRead;
                        cnt_d   = WS;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fire    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fire && acc_rd) begin
            out_d    = rdata;
            rvalid_d = 1'b1;
        end
    end

    // A reset edge suppresses any write, including an aborted pending one.
    assign mem_we = fire & ~acc_rd & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[lane_addr[k]] <= wb[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            rd_q     <= 1'b0;
            out_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            rd_q     <= rd_d;
            out_q    <= out_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign outputData = out_q;
    assign readValid  = rvalid_q;
    assign busy       = (state_q == ST_WAIT);
    assign accessErr  = err_q;

endmodule
